// File: rtl/keypad_if.sv
// keypad_if: keypad matrix pins and decoded key outputs of the scanner
//   row       keypad rows, active-low (row0 = top)
//   col       column drive, active-low, one-cold (col0 = left)
//   num       held one-hot digit, bit k = digit k
//   num_valid one-cycle pulse when num updates
//   star      one-cycle pulse on a debounced * press
//   hash      one-cycle pulse on a debounced # press
//   key_held  high while the stable snapshot has any key down
interface keypad_if;
    logic [3:0] row;
    logic [2:0] col;
    logic [9:0] num;
    logic       num_valid;
    logic       star;
    logic       hash;
    logic       key_held;
    modport master (input row, output col, num, num_valid, star, hash, key_held);
    modport slave  (output row, input col, num, num_valid, star, hash, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans, debounces and decodes a 4x3 matrix keypad
//   clk  system clock
//   rst  asynchronous active-high reset
//   kp   keypad_if.master: row in, column drive and decoded key outputs
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    typedef enum logic [1:0] {COL0, COL1, COL2} state_t;
    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [11:0]   raw_q, raw_d, prev_q, prev_d, stable_q, stable_d, old_q, old_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cmp_q, dec_q, dec_d;
    logic [9:0]    num_q, num_d;
    logic          valid_q, valid_d, star_q, star_d, hash_q, hash_d;
    logic          last;
    logic [1:0]    ci;
    logic [3:0]    key;
    // Snapshot bit layout: bit col*4+row, 1 = pressed.
    always_comb begin
        ci       = state_q;
        last     = dwell_q == DW'(SCAN_DIV - 1);
        state_d  = state_q;
        dwell_d  = dwell_q + 1'b1;
        raw_d    = raw_q;
        prev_d   = prev_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        old_d    = old_q;
        dec_d    = 1'b0;
        if (last) begin
            dwell_d = '0;
            state_d = (state_q == COL2) ? COL0 : state_t'(ci + 2'd1);
            raw_d[{ci, 2'b00} +: 4] = ~sync2_q;
        end
        if (cmp_q) begin
            if (raw_q == prev_q) begin
                cnt_d = (cnt_q == CW'(DEBOUNCE_CNT)) ? cnt_q : cnt_q + 1'b1;
            end else begin
                cnt_d  = '0;
                prev_d = raw_q;
            end
            // Saturated count means prev_q equals raw_q, so it is safe to publish.
            if (cnt_d == CW'(DEBOUNCE_CNT)) begin
                stable_d = prev_q;
                old_d    = stable_q;
                dec_d    = 1'b1;
            end
        end
        // Key code: 0-9 digits, 10 = *, 11 = #.
        key = 4'd0;
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 4; r++)
                if (stable_q[c*4+r])
                    key = (r == 3) ? ((c == 0) ? 4'd10 : (c == 1) ? 4'd0 : 4'd11) : 4'(r*3 + c + 1);
        num_d   = num_q;
        valid_d = 1'b0;
        star_d  = 1'b0;
        hash_d  = 1'b0;
        // Fire only on a clean transition from no keys to exactly one key.
        if (dec_q && old_q == '0 && $onehot(stable_q)) begin
            valid_d = key < 4'd10;
            num_d   = (key < 4'd10) ? 10'(1) << key : num_q;
            star_d  = key == 4'd10;
            hash_d  = key == 4'd11;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= COL0;
            dwell_q  <= '0;
            sync1_q  <= 4'b1111;
            sync2_q  <= 4'b1111;
            raw_q    <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            old_q    <= '0;
            cnt_q    <= '0;
            cmp_q    <= 1'b0;
            dec_q    <= 1'b0;
            num_q    <= '0;
            valid_q  <= 1'b0;
            star_q   <= 1'b0;
            hash_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            sync1_q  <= kp.row;
            sync2_q  <= sync1_q;
            raw_q    <= raw_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            old_q    <= old_d;
            cnt_q    <= cnt_d;
            cmp_q    <= last && state_q == COL2;
            dec_q    <= dec_d;
            num_q    <= num_d;
            valid_q  <= valid_d;
            star_q   <= star_d;
            hash_q   <= hash_d;
        end
    end
    assign kp.col       = (state_q == COL0) ? 3'b110 : (state_q == COL1) ? 3'b101 : 3'b011;
    assign kp.num       = num_q;
    assign kp.num_valid = valid_q;
    assign kp.star      = star_q;
    assign kp.hash      = hash_q;
    assign kp.key_held  = |stable_q;
endmodule
